// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) encode/decode path.
//   CW_LEN/MSG_LEN/SYN_W : codeword, message and syndrome widths
//   DATA_POS             : codeword position of each message bit (msg[0] first)
//   rx_state_t           : serial receiver FSM states
package hamming_pkg;

    localparam int unsigned CW_LEN  = 15;
    localparam int unsigned MSG_LEN = 11;
    localparam int unsigned SYN_W   = 4;

    // Parity sits at the power-of-two positions 1, 2, 4 and 8; data fills the rest.
    localparam logic [SYN_W-1:0] DATA_POS [MSG_LEN] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/hamming15_syndrome_corrector.sv
// Combinational Hamming(15,11) syndrome computation and single-bit correction.
//   cw        in  15  received codeword, cw[p] = position p (1..15)
//   syndrome  out 4   XOR of the indices of all set positions
//   msg       out 11  message extracted after correction
//   corrected out 1   syndrome non-zero, one position flipped
module hamming15_syndrome_corrector
    import hamming_pkg::*;
(
    input  logic [CW_LEN:1]    cw,
    output logic [SYN_W-1:0]   syndrome,
    output logic [MSG_LEN-1:0] msg,
    output logic               corrected
);

    logic [CW_LEN:1] fixed;

    always_comb begin
        syndrome = '0;
        for (int unsigned i = 1; i <= CW_LEN; i++) begin
            if (cw[i]) syndrome = syndrome ^ SYN_W'(i);
        end

        // Every non-zero syndrome names a real position, so no range guard is needed.
        fixed = cw;
        for (int unsigned i = 1; i <= CW_LEN; i++) begin
            if (syndrome == SYN_W'(i)) fixed[i] = ~cw[i];
        end

        msg = '0;
        for (int unsigned k = 0; k < MSG_LEN; k++) begin
            msg[k] = fixed[DATA_POS[k]];
        end

        corrected = (syndrome != '0);
    end

endmodule

// File: rtl/hamming_stream_receiver.sv
// Serial front end of the Hamming(15,11) decoder: synchronises and oversamples
// ser_in, deserialises a start/15-bit/stop frame, corrects single-bit errors.
//   clk, rst_n  clock (rising) / async active-low reset
//   rx_en       receiver enable; low forces IDLE
//   ser_in      serial line, idle 0, start bit 1
//   msg_out     last corrected message (held between strobes)
//   msg_valid   1-cycle strobe: msg_out/syndrome/corrected updated
//   corrected   last frame had a single-bit correction applied
//   syndrome    raw syndrome of the last accepted frame
//   frame_err   1-cycle strobe: stop bit was 1, frame discarded
//   busy        high in START/DATA/STOP
module hamming_stream_receiver
    import hamming_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_en,
    input  logic                ser_in,
    output logic [MSG_LEN-1:0]  msg_out,
    output logic                msg_valid,
    output logic                corrected,
    output logic [SYN_W-1:0]    syndrome,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
    localparam int unsigned BIT_W = $clog2(CW_LEN + 1);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CW_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_SAT   = BIT_W'(CW_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;

    rx_state_t        state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CW_LEN:1]  shreg_q, shreg_d;
    logic             armed_q, armed_d;
    logic             valid_d, ferr_d;
    logic             tick;

    logic [SYN_W-1:0]   dec_syndrome;
    logic [MSG_LEN-1:0] dec_msg;
    logic               dec_corrected;

    hamming15_syndrome_corrector u_corr (
        .cw        (shreg_q),
        .syndrome  (dec_syndrome),
        .msg       (dec_msg),
        .corrected (dec_corrected)
    );

    assign line = sync_q[SYNC_STAGES-1];
    assign tick = (cyc_q == CYC_LAST);
    assign busy = (state_q != RX_IDLE);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        // A start is only accepted once the line has been seen low in IDLE,
        // so a stuck-high stop bit or an aborted frame cannot retrigger.
        armed_d = (state_q == RX_IDLE) ? (armed_q | ~line) : 1'b0;

        if (!rx_en) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (armed_q && line) begin
                        state_d = RX_START;
                        cyc_d   = '0;
                        bit_d   = '0;
                    end
                end
                RX_START: begin
                    if (!line) begin
                        state_d = RX_IDLE;
                    end else if (cyc_q == HALF_LAST) begin
                        state_d = RX_DATA;
                        cyc_d   = '0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        cyc_d = '0;
                        for (int unsigned i = 1; i <= CW_LEN; i++) begin
                            if (bit_q == BIT_W'(i - 1)) shreg_d[i] = line;
                        end
                        if (bit_q != BIT_SAT) bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_d = RX_STOP;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        state_d = RX_IDLE;
                        cyc_d   = '0;
                        if (line) ferr_d  = 1'b1;
                        else      valid_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= RX_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            armed_q   <= 1'b0;
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            msg_out   <= '0;
            syndrome  <= '0;
            corrected <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ser_in};
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            armed_q   <= armed_d;
            msg_valid <= valid_d;
            frame_err <= ferr_d;
            // shreg_q is complete by the stop sample, so decode it directly here.
            if (valid_d) begin
                msg_out   <= dec_msg;
                syndrome  <= dec_syndrome;
                corrected <= dec_corrected;
            end
        end
    end

endmodule

// File: tb/tb_hamming_stream_receiver.sv
module tb_hamming_stream_receiver;

    localparam int BC = 4;

    logic        clk;
    logic        rst_n;
    logic        rx_en;
    logic        ser_in;
    logic [10:0] msg_out;
    logic        msg_valid;
    logic        corrected;
    logic [3:0]  syndrome;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    int n_valid  = 0;
    int n_ferr   = 0;
    int n_both   = 0;
    int n_double = 0;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    hamming_stream_receiver #(
        .BIT_CYCLES  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .ser_in    (ser_in),
        .msg_out   (msg_out),
        .msg_valid (msg_valid),
        .corrected (corrected),
        .syndrome  (syndrome),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and flags overlap or 2-cycle-wide strobes.
    always @(negedge clk) begin
        if (msg_valid) n_valid++;
        if (frame_err) n_ferr++;
        if (msg_valid && frame_err) n_both++;
        if ((msg_valid && prev_v) || (frame_err && prev_f)) n_double++;
        prev_v = msg_valid;
        prev_f = frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        ser_in = b;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:1] cw, input logic stop_bit,
                             output int dv, output int df);
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        drive_bit(1'b1);
        for (int p = 1; p <= 15; p++) drive_bit(cw[p]);
        drive_bit(stop_bit);
        ser_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        dv = n_valid - v0;
        df = n_ferr - f0;
    endtask

    initial begin
        logic [15:1] cw;
        int dv, df, v0, f0, busy_cyc;

        rst_n  = 1'b0;
        rx_en  = 1'b0;
        ser_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_msg_out",   32'(msg_out),   32'h0);
        check_eq("rst_msg_valid", 32'(msg_valid), 32'h0);
        check_eq("rst_syndrome",  32'(syndrome),  32'h0);
        check_eq("rst_corrected", 32'(corrected), 32'h0);
        check_eq("rst_frame_err", 32'(frame_err), 32'h0);
        check_eq("rst_busy",      32'(busy),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: clean all-ones codeword
        cw = 15'h7FFF;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t1_valid_cnt", 32'(dv), 32'd1);
        check_eq("t1_ferr_cnt",  32'(df), 32'd0);
        check_eq("t1_msg",       32'(msg_out),   32'h7FF);
        check_eq("t1_syn",       32'(syndrome),  32'd0);
        check_eq("t1_corr",      32'(corrected), 32'd0);

        // 2: position 5 flipped
        cw = 15'h7FFF;
        cw[5] = 1'b0;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t2_valid_cnt", 32'(dv), 32'd1);
        check_eq("t2_msg",       32'(msg_out),   32'h7FF);
        check_eq("t2_syn",       32'(syndrome),  32'd5);
        check_eq("t2_corr",      32'(corrected), 32'd1);

        // 2b: message 11'h001 (positions 1,2,3) with position 15 flipped -> syndrome 15
        cw = '0;
        cw[1] = 1'b1; cw[2] = 1'b1; cw[3] = 1'b1; cw[15] = 1'b1;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t2b_valid_cnt", 32'(dv), 32'd1);
        check_eq("t2b_msg",       32'(msg_out),   32'h001);
        check_eq("t2b_syn",       32'(syndrome),  32'd15);
        check_eq("t2b_corr",      32'(corrected), 32'd1);

        // 3: zero codeword, position 1 flipped
        cw = '0;
        cw[1] = 1'b1;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t3_valid_cnt", 32'(dv), 32'd1);
        check_eq("t3_msg",       32'(msg_out),   32'h000);
        check_eq("t3_syn",       32'(syndrome),  32'd1);
        check_eq("t3_corr",      32'(corrected), 32'd1);

        // 4: one-cycle glitch while idle
        v0 = n_valid;
        f0 = n_ferr;
        busy_cyc = 0;
        ser_in = 1'b1;
        @(posedge clk);
        #1;
        ser_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
        end
        @(posedge clk);
        #1;
        check_eq("t4_busy_le2",  32'((busy_cyc >= 1) && (busy_cyc <= 2)), 32'd1);
        check_eq("t4_valid_cnt", 32'(n_valid - v0), 32'd0);
        check_eq("t4_ferr_cnt",  32'(n_ferr - f0),  32'd0);

        // 5: bad stop bit
        cw = 15'h7FFF;
        run_frame(cw, 1'b1, dv, df);
        check_eq("t5_ferr_cnt",  32'(df), 32'd1);
        check_eq("t5_valid_cnt", 32'(dv), 32'd0);
        check_eq("t5_msg_hold",  32'(msg_out),   32'h000);
        check_eq("t5_syn_hold",  32'(syndrome),  32'd1);
        check_eq("t5_corr_hold", 32'(corrected), 32'd1);

        // 6a: rx_en dropped after 7 data bits
        v0 = n_valid;
        f0 = n_ferr;
        drive_bit(1'b1);
        for (int p = 1; p <= 7; p++) drive_bit(1'b1);
        check_eq("t6a_busy_mid", 32'(busy), 32'd1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6a_busy_off", 32'(busy), 32'd0);
        ser_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6a_valid_cnt", 32'(n_valid - v0), 32'd0);
        check_eq("t6a_ferr_cnt",  32'(n_ferr - f0),  32'd0);
        check_eq("t6a_msg_hold",  32'(msg_out),  32'h000);
        check_eq("t6a_syn_hold",  32'(syndrome), 32'd1);
        cw = 15'h7FFF;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t6a_next_valid", 32'(dv), 32'd1);
        check_eq("t6a_next_msg",   32'(msg_out),   32'h7FF);
        check_eq("t6a_next_syn",   32'(syndrome),  32'd0);
        check_eq("t6a_next_corr",  32'(corrected), 32'd0);

        // 6b: reset mid-frame
        v0 = n_valid;
        f0 = n_ferr;
        drive_bit(1'b1);
        for (int p = 1; p <= 5; p++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t6b_busy_rst", 32'(busy),    32'd0);
        check_eq("t6b_msg_rst",  32'(msg_out), 32'h000);
        ser_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6b_valid_cnt", 32'(n_valid - v0), 32'd0);
        check_eq("t6b_ferr_cnt",  32'(n_ferr - f0),  32'd0);
        cw = 15'h7FFF;
        run_frame(cw, 1'b0, dv, df);
        check_eq("t6b_next_valid", 32'(dv), 32'd1);
        check_eq("t6b_next_msg",   32'(msg_out),   32'h7FF);
        check_eq("t6b_next_syn",   32'(syndrome),  32'd0);

        // strobe properties across the whole run
        check_eq("strobe_overlap", 32'(n_both),   32'd0);
        check_eq("strobe_2cycle",  32'(n_double), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
